l0_loader: RTL and testbench
============================

# l0_loader

SRAM-to-L0 loader that sits directly upstream of the `l0` row buffer and drives its write side. On a `start` pulse it streams `len` consecutive activation words from the single-port activation SRAM, starting at `base_addr`, into `l0`. It absorbs the SRAM's 1-cycle read latency and `l0` back-pressure (`o_full`) with a 2-entry skid buffer, so no word is ever lost or duplicated. Sustained throughput is 1 word/cycle.

## Interface
Parameters:
- `row`, 8, number of L0 rows (lanes per word)
- `bw`, 4, bits per lane
- `addr_w`, 11, SRAM address width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (asserted at 0); clears all state immediately
- `start`  in  1  sampled in IDLE only; launches a transfer
- `base_addr`  in  addr_w  first SRAM address; sampled with `start`
- `len`  in  addr_w+1  word count, 0..2^addr_w; sampled with `start`
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  1-cycle pulse at transfer end
- `sram_cen`  out  1  SRAM chip enable, active-low
- `sram_wen`  out  1  SRAM write enable, active-low; tied to 1 (read only)
- `sram_addr`  out  addr_w  SRAM read address
- `sram_q`  in  row*bw  SRAM read data, valid the cycle after `sram_cen`=0
- `l0_full`  in  1  `l0` o_full
- `l0_wr`  out  1  write strobe to `l0`
- `l0_in`  out  row*bw  write data to `l0`

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on `start`=1. Latch `base_addr` into the address pointer and `len` into both `remaining` and `to_write`. If `len`=0, go IDLE to DONE instead.
- While in RUN, ignore `start`. Same in DRAIN and DONE.
- Read issue: `sram_cen`=0 iff state=RUN, `remaining`>0 and `occ + inflight - pop` <= 1.
  - `occ`: skid buffer occupancy, 0..2.
  - `inflight`: 1 if a read was issued in the previous cycle.
  - `pop`: equal to `l0_wr`.
- On each issue: `sram_addr` increments modulo 2^addr_w (wrap 0x7FF to 0x000) and `remaining` decrements.
- RUN to DRAIN when the last read issues.
- `inflight` data is captured into the skid buffer unconditionally on the next edge. The credit rule guarantees space.
- Output to `l0`:
  - `l0_wr` = (`occ`>0) & !`l0_full`, combinational.
  - `l0_in` = skid buffer head.
  - Each `l0_wr` decrements `to_write`.
- DRAIN to DONE on the edge where the final `l0_wr` occurs (`to_write` reaches 0). DONE to IDLE after one cycle.
- `done` = (state==DONE).
- Simultaneous push and pop on the skid buffer: `occ` stays unchanged and order is preserved.
- Reset asserted mid-transfer clears the FSM, counters, `occ` and `inflight`. SRAM data already in flight is discarded.
- Reset values: `busy`=0, `done`=0, `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `l0_wr`=0, `l0_in`=0.

## Timing
- Cycle 0: `start`=1, sampled at the end of cycle 0.
- Cycle 1: state=RUN, `sram_cen`=0, `sram_addr`=base.
- Cycle 2: `sram_q`=word0.
- Cycle 3: `l0_wr`=1, `l0_in`=word0.
- With no back-pressure:
  - reads issue in cycles 1..N
  - writes occur in cycles 3..N+2
  - `done` is high in cycle N+3
  - `busy` is high in cycles 1..N+3
- `len`=0: `done` and `busy` are high in cycle 1 only; no SRAM access.
- Combinational paths: `l0_full` to `l0_wr`, and `l0_full` to `sram_cen`. All other outputs are registered or decoded from registers.
- Reads outstanding plus buffered never exceed 2.

## Structure
- Shared package `l0_pkg`:
  - FSM state encoding (IDLE/RUN/DRAIN/DONE)
  - `SKID_DEPTH`=2
  - default `row`/`bw`/`addr_w` constants shared with `l0`
- One sub-module, `l0_skid_buf`: a 2-entry FIFO with ports push/pop/din/dout/occ, the same reset style, and no internal back-pressure checks.
- The FSM, counters and credit logic live in `l0_loader`.

## Test plan
- Basic stream: `len`=4, `base_addr`=0x010, `l0_full`=0, SRAM[a]=a replicated per lane.
  - `sram_addr` = 0x010..0x013 in cycles 1-4.
  - `l0_wr` in cycles 3-6 with data 0x010..0x013 in order.
  - `done` in cycle 7.
- Back-pressure: `len`=8, `l0_full`=1 during cycles 4-7.
  - No more than 2 words issued but unwritten at any time.
  - `l0_wr`=0 throughout the stall.
  - All 8 words delivered exactly once, in order.
  - `done` follows the 8th write by 1 cycle.
- Empty transfer: `len`=0.
  - `sram_cen` stays 1.
  - `done`=1 and `busy`=1 in cycle 1 only.
  - `l0_wr` never asserts.
- Wrap-around: `base_addr`=0x7FE, `len`=4.
  - Addresses 0x7FE, 0x7FF, 0x000, 0x001.
  - Data delivered in that order.
- Reset mid-op: `len`=8, assert `reset`=0 in cycle 4.
  - All outputs take reset values within the same cycle.
  - No `l0_wr` afterwards.
  - A new `start` after release with `len`=2 delivers exactly 2 fresh words.
- Start while busy: second `start` in cycle 3 of a `len`=6 transfer.
  - Ignored.
  - Exactly 6 words are written and one `done` pulse occurs.

Source files
------------

// File: rtl/l0_pkg.sv
// Shared definitions for the L0 row buffer and its SRAM loader:
// default geometry, loader FSM encoding and skid buffer sizing.
package l0_pkg;

    localparam int DEF_ROW    = 8;
    localparam int DEF_BW     = 4;
    localparam int DEF_ADDR_W = 11;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/l0_loader_if.sv
// Control, SRAM read port and L0 write port of the loader, bundled.
// master = loader side, slave = environment (controller, SRAM, l0).
interface l0_loader_if
    import l0_pkg::*;
#(
    parameter int row    = DEF_ROW,
    parameter int bw     = DEF_BW,
    parameter int addr_w = DEF_ADDR_W
);
    logic                  start;
    logic [addr_w-1:0]     base_addr;
    logic [addr_w:0]       len;
    logic                  busy;
    logic                  done;
    logic                  sram_cen;
    logic                  sram_wen;
    logic [addr_w-1:0]     sram_addr;
    logic [row*bw-1:0]     sram_q;
    logic                  l0_full;
    logic                  l0_wr;
    logic [row*bw-1:0]     l0_in;

    // l0 write handshake: l0_wr is only raised when l0_full is low, so every
    // l0_wr cycle is a completed transfer of l0_in; l0_full may change any cycle.
    modport master (
        input  start, base_addr, len, sram_q, l0_full,
        output busy, done, sram_cen, sram_wen, sram_addr, l0_wr, l0_in
    );

    modport slave (
        output start, base_addr, len, sram_q, l0_full,
        input  busy, done, sram_cen, sram_wen, sram_addr, l0_wr, l0_in
    );

endinterface

// File: rtl/l0_skid_buf.sv
// Small in-order FIFO catching SRAM read data; the caller's credit logic
// guarantees it never overflows or underflows, so no checks live here.
module l0_skid_buf
    import l0_pkg::*;
#(
    parameter int W = DEF_ROW * DEF_BW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [SKID_OCC_W-1:0] occ
);

    logic [W-1:0]          mem_q [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SKID_OCC_W-1:0] occ_q, occ_d;

    function automatic logic [SKID_PTR_W-1:0] ptr_inc(input logic [SKID_PTR_W-1:0] p);
        return (p == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/l0_loader.sv
// Streams len words from the activation SRAM into l0, hiding the 1-cycle
// SRAM read latency and l0 back-pressure behind a 2-entry skid buffer.
module l0_loader
    import l0_pkg::*;
#(
    parameter int row    = DEF_ROW,
    parameter int bw     = DEF_BW,
    parameter int addr_w = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    l0_loader_if.master bus,
    output state_t      dbg_state_o
);

    localparam int W = row * bw;

    state_t                state_q, state_d;
    logic [addr_w-1:0]     addr_q, addr_d;
    logic [addr_w:0]       remaining_q, remaining_d;
    logic [addr_w:0]       to_write_q, to_write_d;
    logic                  inflight_q;
    logic [SKID_OCC_W-1:0] occ;
    logic [W-1:0]          head;
    logic [2:0]            credit;
    logic                  issue;
    logic                  pop;

    l0_skid_buf #(.W(W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (pop),
        .din   (bus.sram_q),
        .dout  (head),
        .occ   (occ)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (remaining_q == (addr_w+1)'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (to_write_q == (addr_w+1)'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; a read may issue only if its word is sure to find a
    // free skid slot once it lands, counting the pop happening this cycle.
    always_comb begin
        credit        = {{(3-SKID_OCC_W){1'b0}}, occ} + {2'b00, inflight_q};
        pop           = (occ != '0) && !bus.l0_full;
        issue         = (state_q == ST_RUN) && (remaining_q != '0)
                        && (credit <= 3'd1 + {2'b00, pop});
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.sram_cen  = !issue;
        bus.sram_wen  = 1'b1;
        bus.sram_addr = addr_q;
        bus.l0_wr     = pop;
        bus.l0_in     = head;
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        to_write_d  = to_write_q;
        if ((state_q == ST_IDLE) && bus.start) begin
            addr_d      = bus.base_addr;
            remaining_d = bus.len;
            to_write_d  = bus.len;
        end
        if (issue) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
        if (pop) begin
            to_write_d = to_write_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            to_write_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            to_write_q  <= to_write_d;
            inflight_q  <= issue;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l0_loader.sv
// Directed bench for l0_loader: behavioural 1-cycle SRAM, per-cycle checks
// against hand-derived timing, and an expected-word queue per transfer.
module tb_l0_loader;
    import l0_pkg::*;

    localparam int ROW    = 8;
    localparam int BW     = 4;
    localparam int ADDR_W = 11;
    localparam int W      = ROW * BW;

    logic   clk;
    logic   reset;
    state_t dbg_state;

    l0_loader_if #(.row(ROW), .bw(BW), .addr_w(ADDR_W)) bus ();

    l0_loader #(.row(ROW), .bw(BW), .addr_w(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[9:0], a, a};
    endfunction

    always @(posedge clk) begin
        if (!bus.sram_cen) bus.sram_q <= mem_word(bus.sram_addr);
    end

    int n_checks;
    int n_errors;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int done_cnt;
    int outst;
    int max_out;
    int last_wr;
    int done_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (bus.l0_wr === 1'b1) got_q.push_back(bus.l0_in);
        if (bus.done === 1'b1) done_cnt++;
        if (!reset) begin
            outst = 0;
        end else begin
            if (bus.sram_cen === 1'b0) outst++;
            if (bus.l0_wr === 1'b1) outst--;
        end
        if (outst > max_out) max_out = outst;
    endtask

    task automatic sample();
        #1;
        observe();
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        last_wr  = -1;
        done_c   = -1;
    endtask

    // cycle 0 of a transfer
    task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n);
        step();
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.len       = n;
        sample();
    endtask

    task automatic expect_stream(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem_word(a));
            a = a + 1'b1;
        end
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_data"}, got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        n_checks = 0;
        n_errors = 0;
        outst    = 0;
        max_out  = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.l0_full   = 1'b0;
        new_test();

        // reset values
        step();
        sample();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_cen", bus.sram_cen, 1'b1);
        chk("rst_wen", bus.sram_wen, 1'b1);
        chk("rst_addr", bus.sram_addr, 11'h000);
        chk("rst_wr", bus.l0_wr, 1'b0);
        chk("rst_l0_in", bus.l0_in, 32'h0);
        chk("rst_state", dbg_state, ST_IDLE);
        step();
        reset = 1'b1;
        sample();

        // basic stream: len 4 from 0x010
        new_test();
        expect_stream(11'h010, 4);
        launch(11'h010, 12'd4);
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.start = 1'b0;
            sample();
            chk("basic_busy", bus.busy, (c <= 7));
            chk("basic_done", bus.done, (c == 7));
            chk("basic_cen", bus.sram_cen, !(c <= 4));
            if (c <= 4) chk("basic_addr", bus.sram_addr, 11'h010 + 11'(c - 1));
            chk("basic_wr", bus.l0_wr, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("basic_data", bus.l0_in, mem_word(11'h010 + 11'(c - 3)));
        end
        compare_stream("basic");

        // back-pressure: len 8, l0_full high in cycles 4..7
        new_test();
        expect_stream(11'h100, 8);
        launch(11'h100, 12'd8);
        for (int c = 1; c <= 18; c++) begin
            step();
            bus.start   = 1'b0;
            bus.l0_full = (c >= 4 && c <= 7);
            sample();
            if (c >= 4 && c <= 7) chk("bp_stall_wr", bus.l0_wr, 1'b0);
            if (bus.l0_wr === 1'b1) last_wr = c;
            if (bus.done === 1'b1) done_c = c;
        end
        bus.l0_full = 1'b0;
        compare_stream("bp");
        chk("bp_last_wr_cycle", last_wr, 14);
        chk("bp_done_cycle", done_c, 15);
        chk("bp_done_pulses", done_cnt, 1);
        chk("bp_max_outstanding_le2", (max_out <= 2), 1'b1);

        // empty transfer
        new_test();
        launch(11'h055, 12'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.start = 1'b0;
            sample();
            chk("empty_cen", bus.sram_cen, 1'b1);
            chk("empty_wr", bus.l0_wr, 1'b0);
            chk("empty_done", bus.done, (c == 1));
            chk("empty_busy", bus.busy, (c == 1));
        end

        // wrap-around at the top of the address space
        new_test();
        expect_stream(11'h7FE, 4);
        launch(11'h7FE, 12'd4);
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.start = 1'b0;
            sample();
            a = 11'h7FE + 11'(c - 1);
            if (c <= 4) chk("wrap_addr", bus.sram_addr, a);
        end
        compare_stream("wrap");
        chk("wrap_done_pulses", done_cnt, 1);

        // reset asserted in cycle 4 of a len 8 transfer
        new_test();
        launch(11'h500, 12'd8);
        for (int c = 1; c <= 3; c++) begin
            step();
            bus.start = 1'b0;
            sample();
        end
        step();
        reset = 1'b0;
        sample();
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_cen", bus.sram_cen, 1'b1);
        chk("midrst_wen", bus.sram_wen, 1'b1);
        chk("midrst_addr", bus.sram_addr, 11'h000);
        chk("midrst_wr", bus.l0_wr, 1'b0);
        chk("midrst_l0_in", bus.l0_in, 32'h0);
        step();
        sample();
        step();
        reset = 1'b1;
        sample();
        new_test();
        for (int c = 0; c < 5; c++) begin
            step();
            sample();
        end
        chk("midrst_no_wr_after", got_q.size(), 0);
        new_test();
        expect_stream(11'h200, 2);
        launch(11'h200, 12'd2);
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.start = 1'b0;
            sample();
        end
        compare_stream("midrst_restart");
        chk("midrst_restart_done", done_cnt, 1);

        // second start while busy is ignored
        new_test();
        expect_stream(11'h300, 6);
        launch(11'h300, 12'd6);
        for (int c = 1; c <= 14; c++) begin
            step();
            bus.start     = (c == 3);
            bus.base_addr = (c == 3) ? 11'h400 : 11'h300;
            bus.len       = (c == 3) ? 12'd3 : 12'd6;
            sample();
            if (bus.done === 1'b1) done_c = c;
        end
        bus.start = 1'b0;
        compare_stream("busy_start");
        chk("busy_start_done_pulses", done_cnt, 1);
        chk("busy_start_done_cycle", done_c, 9);

        chk("max_outstanding_le2", (max_out <= 2), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
